// File: rtl/moving_average_filter.sv
// Boxcar moving average over the last 2**WIN_LOG2 samples of ui_in.
// The 8-bit average drives uio_out. uo_out[6:0] shows its high nibble on a
// 7-segment display, and uo_out[7] flags that the window has filled.
// rst_n keeps the tile's port name but is a synchronous, active-high reset.
module moving_average_filter #(
  parameter int WIN_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int N     = 1 << WIN_LOG2;
  localparam int SUM_W = 8 + WIN_LOG2;

  // The fill count saturates at N, so it needs one bit more than the pointer.
  localparam logic [WIN_LOG2:0] FILL_FULL = {1'b1, {WIN_LOG2{1'b0}}};

  logic [7:0]          hist [N];
  logic [WIN_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]    sum;
  logic [WIN_LOG2:0]   fill;
  logic [SUM_W-1:0]    sum_next;
  logic [7:0]          avg;
  logic [6:0]          seg;
  logic                full;

  // The bidirectional pins are inputs to nothing in this tile.
  logic unused_bits;
  assign unused_bits = &{1'b0, uio_in};

  // wr_ptr always points at the oldest entry, which is replaced by the new
  // sample. Modular arithmetic is exact: the sum never goes negative, and
  // it never exceeds N*255.
  always_comb begin
    sum_next = sum + {{WIN_LOG2{1'b0}}, ui_in} - {{WIN_LOG2{1'b0}}, hist[wr_ptr]};
  end

  // History, running sum and fill counter. Reset has priority over ena.
  // NOTE: the history array is reset too. The running sum subtracts the
  // entry that leaves the window, so a stale value would corrupt the average.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        hist[i] <= 8'h00;
      end
      wr_ptr <= '0;
      sum    <= '0;
      fill   <= '0;
    end else if (ena) begin
      hist[wr_ptr] <= ui_in;
      wr_ptr       <= wr_ptr + WIN_LOG2'(1);
      sum          <= sum_next;
      if (fill != FILL_FULL) begin
        fill <= fill + (WIN_LOG2 + 1)'(1);
      end
    end
  end

  assign avg  = sum[SUM_W-1:WIN_LOG2];
  assign full = (fill == FILL_FULL);

  // Hex digit decoder for avg[7:4]; segments a..g map to bits 0..6, active-high.
  always_comb begin
    seg = 7'h00;
    case (avg[7:4])
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

  assign uio_out = avg;
  assign uo_out  = {full, seg};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_moving_average_filter.sv
// Self-checking bench for moving_average_filter (N = 4).
// The reference model keeps the window as a queue of the last N accepted
// samples. It computes the average as their sum divided by N and looks up the
// digit in a table.
module tb_moving_average_filter;

  localparam int WIN_LOG2 = 2;
  localparam int N        = 1 << WIN_LOG2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  moving_average_filter #(.WIN_LOG2(WIN_LOG2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int         win[$];
  int         accepts;
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_avg();
    int s = 0;
    foreach (win[i]) s += win[i];
    return 8'(s / N);
  endfunction

  function automatic logic [7:0] model_uo();
    logic [7:0] a = model_avg();
    return {(accepts >= N), seg_tab[a[7:4]]};
  endfunction

  task automatic model_reset();
    win.delete();
    for (int i = 0; i < N; i++) win.push_back(0);
    accepts = 0;
  endtask

  // Drive one clock cycle: inputs change on the falling edge, the model is
  // updated at the rising edge, and the outputs are sampled 1 time unit later.
  task automatic cycle(input logic r, input logic e, input logic [7:0] d);
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    ui_in  = d;
    uio_in = 8'($urandom);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (e) begin
      win.push_back(int'(d));
      void'(win.pop_front());
      accepts++;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".avg"}, uio_out, model_avg());
    check({tag, ".uo"},  uo_out,  model_uo());
    check({tag, ".oe"},  uio_oe,  8'hFF);
  endtask

  logic [7:0] exp_avg [4];
  logic [7:0] exp_seg [4];
  logic [7:0] held_avg, held_uo;

  initial begin
    model_reset();

    // Reset for two edges.
    cycle(1'b1, 1'b1, 8'h55);
    cycle(1'b1, 1'b0, 8'h00);
    check("reset.avg", uio_out, 8'h00);
    check("reset.uo",  uo_out,  8'h3F);
    check("reset.oe",  uio_oe,  8'hFF);
    check_model("reset");

    // Ramp: accept 0x80 four times.
    exp_avg = '{8'h20, 8'h40, 8'h60, 8'h80};
    exp_seg = '{8'h5B, 8'h66, 8'h7D, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'h80);
      check($sformatf("ramp%0d.avg", i), uio_out, exp_avg[i]);
      check($sformatf("ramp%0d.uo", i),  uo_out,  exp_seg[i]);
    end

    // Decay: accept 0x00 four times; the full flag stays set.
    exp_avg = '{8'h60, 8'h40, 8'h20, 8'h00};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check($sformatf("decay%0d.avg", i), uio_out, exp_avg[i]);
      check($sformatf("decay%0d.flag", i), {7'h0, uo_out[7]}, 8'h01);
      check_model($sformatf("decay%0d", i));
    end

    // Truncation: a window of 1,1,1,2 sums to 5, which averages to 1.
    cycle(1'b0, 1'b1, 8'h01);
    cycle(1'b0, 1'b1, 8'h01);
    cycle(1'b0, 1'b1, 8'h01);
    cycle(1'b0, 1'b1, 8'h02);
    check("trunc.avg", uio_out, 8'h01);
    check_model("trunc");

    // Maximum: a full window of 0xFF.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'hFF);
    check("max.avg", uio_out, 8'hFF);
    check("max.uo",  uo_out,  8'hF1);

    // Hold: ena=0 for 10 edges with random data.
    held_avg = model_avg();
    held_uo  = model_uo();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 8'($urandom));
      check($sformatf("hold%0d.avg", i), uio_out, held_avg);
      check($sformatf("hold%0d.uo", i),  uo_out,  held_uo);
    end

    // Reset mid-ramp, with ena high during the reset edge.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h80);
    cycle(1'b0, 1'b1, 8'h80);
    check_model("midramp");
    cycle(1'b1, 1'b1, 8'h80);
    check("midrst.avg", uio_out, 8'h00);
    check("midrst.uo",  uo_out,  8'h3F);
    cycle(1'b0, 1'b1, 8'h40);
    check("restart.avg", uio_out, 8'h10);
    check_model("restart");

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
      check_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/moving_average_filter.md
Name: moving_average_filter

Overview:
- Top-level TinyTapeout-style tile computing a running (boxcar) moving average of 8-bit samples on ui_in.
- Full 8-bit average drives uio_out; its high nibble is shown as a hex digit on a 7-segment display at uo_out[6:0].
- uo_out[7] flags that the averaging window has been completely filled since reset.

Parameters:
- WIN_LOG2, 2, log2 of window length; window N = 2**WIN_LOG2 samples (legal 1..4, default N=4).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-high: state clears on a rising clk edge while rst_n=1 (name kept from tile convention; polarity is high-active).
- ena  input  1  sample enable; a sample is accepted on each rising edge with ena=1 and rst_n=0.
- ui_in  input  8  unsigned sample value.
- uio_in  input  8  unused; ignored.
- uo_out  output  8  [6:0] 7-segment pattern of avg[7:4]; [7] window-full flag.
- uio_out  output  8  current average avg[7:0].
- uio_oe  output  8  constant 8'hFF (all bidirectional pins driven as outputs).

Behaviour:
- State:
  - Sample history: N entries x 8 bits, a circular buffer or shift register.
  - Running sum: 8+WIN_LOG2 bits, unsigned.
  - Fill counter: WIN_LOG2+1 bits, saturating at N.
- Reset (rst_n=1 at edge): all history entries=0, sum=0, fill count=0. Reset has priority over ena.
- Resulting outputs after reset:
  - uio_out=8'h00
  - uo_out=8'h3F (digit 0, flag 0)
  - uio_oe=8'hFF at all times.
- Accept edge (ena=1, rst_n=0):
  - Oldest entry leaves the window; ui_in enters.
  - sum_next = sum + ui_in - oldest, in 8+WIN_LOG2 bits. Never overflows or underflows.
  - Fill count increments until it equals N, then holds.
- Before the window fills, unfilled entries count as 0. The average therefore ramps up; there is no division by the partial count.
- avg = sum >> WIN_LOG2 (truncating, unsigned), driven combinationally from the sum register.
- Latency: a sample accepted on edge k is reflected on uio_out/uo_out immediately after edge k (one clock, no extra pipeline).
- ena=0: all state holds; outputs hold.
- uo_out[7] = 1 exactly when fill count = N. It stays 1 until the next reset.
- 7-seg encoding, bit0=a ... bit6=g, active-high. Values are the seg[6:0] pattern, hex; digit F (8'h71) includes g:
  - 0:3F 1:06 2:5B 3:4F
  - 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C
  - C:39 d:5E E:79 F:71
- Decoder is purely combinational from avg[7:4]; no X/undefined patterns for any input.
- Reset mid-operation: the next edge with rst_n=1 discards history, sum and flag regardless of ena. Accumulation restarts from zero.
- No internal overflow, wrap or saturation path other than the fill counter saturating at N.

Test Plan:
- Reset: rst_n=1 for 2 edges -> uio_out=00, uo_out=3F, uio_oe=FF.
- Ramp with N=4 (four accepts of 0x80):
  - uio_out after each accept = 20, 40, 60, 80.
  - uo_out[6:0] = 5B, 66, 7D, 7F.
  - uo_out[7] = 0, 0, 0, 1; flag is 1 only after the 4th accept.
- Decay: from a full window of 0x80, accept 0x00 x4 -> uio_out 60, 40, 20, 00; uo_out[7] stays 1.
- Truncation and max:
  - Accept 01, 01, 01, 02 -> uio_out=01 (sum 5>>2).
  - Then accept FF x4 -> uio_out=FF, uo_out=F1.
- Hold with ena=0 for 10 edges and random ui_in -> uio_out/uo_out unchanged.
- Reset mid-ramp: after 2 accepts of 0x80, assert rst_n=1 with ena=1 -> outputs 00/3F.
  - Then accept 0x40 -> uio_out=10.
